fake_netlist_bist_driver: RTL and testbench

//   Stimulus/response end for 14-input, 1-output combinational netlist blocks

---
 rtl/fake_netlist_bist_driver_if.sv | 25 ++
 rtl/fake_netlist_bist_driver.sv | 84 ++++++++
 tb/tb_fake_netlist_bist_driver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fake_netlist_bist_driver_if.sv
// Control and netlist-facing signals of the BIST driver, bundled so the test
// controller / netlist side and the driver side each get one modport.
interface fake_netlist_bist_driver_if #(
    parameter int IN_W = 14
);
    logic            start;
    logic [IN_W-1:0] seed;
    logic [15:0]     expected_sig;
    logic [IN_W-1:0] pattern_out;
    logic            resp_in;
    logic            busy;
    logic            done;
    logic [15:0]     signature;
    logic            pass;

    modport master (
        output start, seed, expected_sig, resp_in,
        input  pattern_out, busy, done, signature, pass
    );

    modport slave (
        input  start, seed, expected_sig, resp_in,
        output pattern_out, busy, done, signature, pass
    );
endinterface

// File: rtl/fake_netlist_bist_driver.sv
// BIST driver for 14-input / 1-output netlist blocks: LFSR pattern source,
// 16-bit MISR response compactor and a golden-signature comparison.
module fake_netlist_bist_driver #(
    parameter int IN_W       = 14,
    parameter int N_PATTERNS = 1024,
    parameter int CNT_W      = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    fake_netlist_bist_driver_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(N_PATTERNS - 1);
    localparam logic [IN_W-1:0]  SEED_ONE  = IN_W'(1);

    state_t            state_q;
    logic [IN_W-1:0]   pat_q;
    logic [IN_W-1:0]   pat_d;
    logic [15:0]       sig_q;
    logic [15:0]       sig_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic              pass_q;

    // Tap sets x^14+x^13+x^12+x^2+1 (pattern) and x^16+x^15+x^13+x^4+1 (MISR).
    assign pat_d = {pat_q[IN_W-2:0], pat_q[13] ^ pat_q[12] ^ pat_q[11] ^ pat_q[1]};
    assign sig_d = {sig_q[14:0], sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3] ^ bus.resp_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            sig_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q <= S_RUN;
                        pat_q   <= (bus.seed == '0) ? SEED_ONE : bus.seed;
                        sig_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                S_RUN: begin
                    sig_q <= sig_d;
                    cnt_q <= cnt_q + 1'b1;
                    // The final pattern stays on the outputs through DONE.
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        pat_q <= pat_d;
                    end
                end
                S_DONE: begin
                    pass_q  <= (sig_q == bus.expected_sig);
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.pattern_out = pat_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.signature   = sig_q;
    assign bus.pass        = pass_q;
endmodule

// File: tb/tb_fake_netlist_bist_driver.sv
// Randomized self-checking bench for fake_netlist_bist_driver with a
// behavioural pattern/signature model and a parity-function fake netlist.
module tb_fake_netlist_bist_driver;
    localparam int N    = 4;
    localparam int IN_W = 14;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fake_netlist_bist_driver_if #(.IN_W(IN_W)) bus ();

    fake_netlist_bist_driver #(
        .IN_W      (IN_W),
        .N_PATTERNS(N),
        .CNT_W     (3)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Fake netlist: parity of a masked subset of the inputs, optionally inverted.
    logic [IN_W-1:0] resp_mask;
    logic            resp_inv;
    assign bus.resp_in = (^(bus.pattern_out & resp_mask)) ^ resp_inv;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: m_pat[i] is the i-th applied pattern, m_sig[i] the
    // signature after i captured responses.
    int m_pat[$];
    int m_sig[$];

    function automatic int parity(input int v);
        int p = 0;
        for (int b = 0; b < 32; b++) p ^= (v >> b) & 1;
        return p;
    endfunction

    task automatic build_model(input int seed);
        int p;
        int s;
        int r;
        m_pat.delete();
        m_sig.delete();
        p = (seed == 0) ? 1 : seed;
        s = 0;
        m_sig.push_back(s);
        for (int i = 0; i < N; i++) begin
            m_pat.push_back(p);
            r = parity(p & int'(resp_mask)) ^ int'(resp_inv);
            s = ((s << 1) & 16'hFFFF)
                | (((s >> 15) ^ (s >> 14) ^ (s >> 12) ^ (s >> 3) ^ r) & 1);
            m_sig.push_back(s);
            p = ((p << 1) & 16'h3FFF)
                | (((p >> 13) ^ (p >> 12) ^ (p >> 11) ^ (p >> 1)) & 1);
        end
    endtask

    task automatic run(input logic [IN_W-1:0] seed, input logic [15:0] exp_sig, input bit poke);
        build_model(int'(seed));
        @(negedge clk);
        bus.seed         = seed;
        bus.expected_sig = exp_sig;
        bus.start        = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            check_eq($sformatf("run_busy[%0d]", i), bus.busy, 1);
            check_eq($sformatf("run_done[%0d]", i), bus.done, 0);
            check_eq($sformatf("run_pat[%0d]", i), bus.pattern_out, m_pat[i]);
            check_eq($sformatf("run_sig[%0d]", i), bus.signature, m_sig[i]);
            bus.start = poke && (i == 1);
        end
        @(negedge clk);
        check_eq("done_pulse", bus.done, 1);
        check_eq("done_busy", bus.busy, 0);
        check_eq("done_sig", bus.signature, m_sig[N]);
        check_eq("done_pat_held", bus.pattern_out, m_pat[N-1]);
        bus.start = poke;
        @(negedge clk);
        bus.start = 1'b0;
        check_eq("idle_done", bus.done, 0);
        check_eq("idle_busy", bus.busy, 0);
        check_eq("idle_pass", bus.pass, (m_sig[N] == int'(exp_sig)) ? 1 : 0);
        check_eq("idle_sig_held", bus.signature, m_sig[N]);
        if (poke) begin
            @(negedge clk);
            check_eq("poke_ignored_busy", bus.busy, 0);
            check_eq("poke_ignored_pat", bus.pattern_out, m_pat[N-1]);
        end
        $display("run seed=0x%04h exp=0x%04h sig=0x%04h pass=%0d", seed, exp_sig, bus.signature, bus.pass);
    endtask

    initial begin
        int done_cyc[$];
        int done_sig[$];
        rst              = 1'b1;
        bus.start        = 1'b0;
        bus.seed         = '0;
        bus.expected_sig = '0;
        resp_mask        = '0;
        resp_inv         = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_pat", bus.pattern_out, 0);
        check_eq("rst_sig", bus.signature, 0);
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_done", bus.done, 0);
        check_eq("rst_pass", bus.pass, 0);

        // Constant-0 response, seed 1, golden 0.
        run(14'd1, 16'h0000, 1'b0);
        check_eq("s1_last_pat", bus.pattern_out, 14'h000A);
        check_eq("s2_pass", bus.pass, 1);

        // Constant-1 response against a wrong golden value.
        resp_inv = 1'b1;
        run(14'd1, 16'h000E, 1'b0);
        check_eq("s3_sig", bus.signature, 16'h000F);
        check_eq("s3_pass", bus.pass, 0);

        // Seed 0 behaves exactly like seed 1.
        resp_inv = 1'b0;
        run(14'd0, 16'h0000, 1'b0);

        // Abort on the second RUN cycle.
        @(negedge clk);
        bus.seed  = 14'h1234;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("abort_pat", bus.pattern_out, 0);
        check_eq("abort_sig", bus.signature, 0);
        check_eq("abort_busy", bus.busy, 0);
        check_eq("abort_pass", bus.pass, 0);
        for (int i = 0; i < N + 2; i++) begin
            check_eq($sformatf("abort_no_done[%0d]", i), bus.done, 0);
            @(negedge clk);
        end
        $display("abort seed=0x1234 pat=0x%04h sig=0x%04h", bus.pattern_out, bus.signature);

        // Clean run after abort, with start poked during RUN and DONE.
        resp_mask = 14'h2A5B;
        run(14'h0155, 16'h0000, 1'b1);

        // start held high: back-to-back runs.
        resp_mask = 14'h1C37;
        resp_inv  = 1'b1;
        build_model(14'h0ABC);
        @(negedge clk);
        bus.seed  = 14'h0ABC;
        bus.start = 1'b1;
        for (int c = 0; c < 3 * (N + 2) + 4 && done_cyc.size() < 2; c++) begin
            @(negedge clk);
            if (bus.done) begin
                done_cyc.push_back(c);
                done_sig.push_back(int'(bus.signature));
                if (done_cyc.size() == 2) bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check_eq("held_done_count", done_cyc.size(), 2);
        if (done_cyc.size() == 2) begin
            check_eq("held_spacing", done_cyc[1] - done_cyc[0], N + 2);
            check_eq("held_sig0", done_sig[0], m_sig[N]);
            check_eq("held_sig1", done_sig[1], m_sig[N]);
            $display("held done@%0d,%0d sig=0x%04h,0x%04h", done_cyc[0], done_cyc[1], done_sig[0], done_sig[1]);
        end
        repeat (N + 3) @(negedge clk);

        // Randomized runs.
        for (int r = 0; r < 12; r++) begin
            logic [IN_W-1:0] seed;
            logic [15:0]     exp;
            seed      = IN_W'($urandom);
            if (r % 4 == 0) seed = '0;
            resp_mask = IN_W'($urandom);
            resp_inv  = 1'($urandom);
            build_model(int'(seed));
            exp = ($urandom_range(0, 1) == 1) ? 16'(m_sig[N]) : 16'($urandom);
            run(seed, exp, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
